// File: rtl/sevenseg_pkg.sv
// Shared types and the hex glyph table for the seven-segment scan controller.
// Segment vectors are ordered {CA,CB,CC,CD,CE,CF,CG} and are active-low.
package sevenseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous double buffering.
// Optional SEVENSEG_DIMMING_EN adds i_duty for per-frame PWM brightness within the ON phase.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned REFRESH_HZ    = 1000,
  parameter int unsigned BLANK_CYCLES  = 64,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_update,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [7*NUM_DIGITS-1:0] i_raw,
  input  logic                    i_raw_mode,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
`ifdef SEVENSEG_DIMMING_EN
  input  logic [3:0]              i_duty,
`endif
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int unsigned SLOT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_digits_chk
    $error("NUM_DIGITS must be in 1..16");
  end
  if (SLOT_CYCLES <= BLANK_CYCLES) begin : g_slot_chk
    $error("SLOT_CYCLES must exceed BLANK_CYCLES");
  end

  // Scan sequencer
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             w_slot_end, w_boundary;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_slot_end  = (r_cnt == CNT_LAST);
    w_boundary  = w_slot_end && (r_idx == IDX_LAST);
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_state_nxt = r_state;
    if (w_slot_end) begin
      w_cnt_nxt = '0;
      w_idx_nxt = w_boundary ? '0 : r_idx + 1'b1;
    end
    case (r_state)
      BLANK:   if (w_cnt_nxt >= CNT_BLANK) w_state_nxt = ON;
      ON:      if (w_cnt_nxt < CNT_BLANK) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  // Staging / active double buffer; active only changes at the frame boundary
  logic [4*NUM_DIGITS-1:0] r_stg_value, r_act_value;
  logic [7*NUM_DIGITS-1:0] r_stg_raw, r_act_raw;
  logic [NUM_DIGITS-1:0]   r_stg_dp, r_act_dp, r_stg_en, r_act_en;
  logic                    r_stg_raw_mode, r_act_raw_mode, r_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_value    <= '0;
      r_stg_raw      <= '0;
      r_stg_dp       <= '0;
      r_stg_en       <= '0;
      r_stg_raw_mode <= 1'b0;
      r_act_value    <= '0;
      r_act_raw      <= '0;
      r_act_dp       <= '0;
      r_act_en       <= '0;
      r_act_raw_mode <= 1'b0;
      r_pending      <= 1'b0;
    end else begin
      if (w_boundary && r_pending) begin
        r_act_value    <= r_stg_value;
        r_act_raw      <= r_stg_raw;
        r_act_dp       <= r_stg_dp;
        r_act_en       <= r_stg_en;
        r_act_raw_mode <= r_stg_raw_mode;
      end
      if (w_boundary) r_pending <= 1'b0;
      // An update on the boundary lands in staging after the copy and stays pending
      if (i_update) begin
        r_stg_value    <= i_value;
        r_stg_raw      <= i_raw;
        r_stg_dp       <= i_dp;
        r_stg_en       <= i_digit_en;
        r_stg_raw_mode <= i_raw_mode;
        r_pending      <= 1'b1;
      end
    end
  end

  logic w_dim_on;

`ifdef SEVENSEG_DIMMING_EN
  localparam int unsigned SUB_CYCLES = (SLOT_CYCLES - BLANK_CYCLES) / 16;

  if (SLOT_CYCLES < BLANK_CYCLES + 16) begin : g_dim_chk
    $error("ON phase must be at least 16 cycles for dimming");
  end

  logic [3:0] r_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_duty <= 4'h0;
    else if (w_boundary) r_duty <= i_duty;
  end

  // Subslots 0..r_duty lit; full duty also covers any remainder cycles
  assign w_dim_on = (r_duty == 4'hF) ||
                    ((32'(r_cnt) - BLANK_CYCLES) < (32'(r_duty) + 1) * SUB_CYCLES);
`else
  assign w_dim_on = 1'b1;
`endif

  // Output datapath
  logic [3:0]            w_val_arr [NUM_DIGITS];
  logic [6:0]            w_raw_arr [NUM_DIGITS];
  logic [3:0]            w_nibble;
  logic [6:0]            w_hex_seg;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_onehot, w_an_nxt;
  logic [6:0]            w_seg_nxt;
  logic                  w_dp_nxt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_unpack
    assign w_val_arr[g] = r_act_value[4*g +: 4];
    assign w_raw_arr[g] = r_act_raw[7*g +: 7];
  end

  assign w_nibble = w_val_arr[r_idx];

  sevenseg_hex_decode u_hex_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_hex_seg)
  );

  always_comb begin
    w_lit     = (r_state == ON) && r_act_en[r_idx] && w_dim_on;
    w_onehot  = NUM_DIGITS'(1) << r_idx;
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b1;
    if (w_lit) begin
      w_an_nxt  = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
      w_seg_nxt = r_act_raw_mode ? w_raw_arr[r_idx] : w_hex_seg;
      w_dp_nxt  = ~r_act_dp[r_idx];
    end
  end

  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp, r_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
      r_frame <= w_boundary;
    end
  end

  assign o_an    = r_an;
  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl: a per-cycle reference model pushes expected pin
// states, a negedge monitor pops and compares; directed checks cover the key scenarios.
module tb_sevenseg_scan_ctrl;

  localparam int unsigned N       = 8;
  localparam int unsigned REFRESH = 10;
  localparam int unsigned BLANK   = 2;
`ifdef SEVENSEG_DIMMING_EN
  localparam int unsigned CLKF    = 2720;
`else
  localparam int unsigned CLKF    = 800;
`endif
  localparam int unsigned SLOT    = CLKF / (REFRESH * N);
  localparam int unsigned FRAME   = SLOT * N;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_update = 1'b0;
  logic [31:0]  i_value = '0;
  logic [55:0]  i_raw = '0;
  logic         i_raw_mode = 1'b0;
  logic [7:0]   i_dp = '0;
  logic [7:0]   i_digit_en = '0;
  logic [7:0]   o_an;
  logic [6:0]   o_seg;
  logic         o_dp;
  logic         o_frame;
`ifdef SEVENSEG_DIMMING_EN
  logic [3:0]   i_duty = 4'hF;
`endif

  sevenseg_scan_ctrl #(
    .NUM_DIGITS    (N),
    .CLK_FREQ_HZ   (CLKF),
    .REFRESH_HZ    (REFRESH),
    .BLANK_CYCLES  (BLANK),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_update   (i_update),
    .i_value    (i_value),
    .i_raw      (i_raw),
    .i_raw_mode (i_raw_mode),
    .i_dp       (i_dp),
    .i_digit_en (i_digit_en),
`ifdef SEVENSEG_DIMMING_EN
    .i_duty     (i_duty),
`endif
    .o_an       (o_an),
    .o_seg      (o_seg),
    .o_dp       (o_dp),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] value;
    logic [55:0] raw;
    logic        raw_mode;
    logic [7:0]  dp;
    logic [7:0]  en;
  } upd_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  upd_t        upd_q[$];
  exp_t        exp_q[$];
  int unsigned cyc;
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef SEVENSEG_DIMMING_EN
  localparam int unsigned SUB = (SLOT - BLANK) / 16;
  typedef struct {
    int unsigned cyc;
    int unsigned duty;
  } duty_t;
  duty_t duty_q[$];

  // Duty in force for frame f is whatever i_duty held on that frame's opening boundary cycle
  function automatic bit dim_lit(input int unsigned f, input int unsigned p);
    int unsigned duty = 0;
    foreach (duty_q[i]) if (f > 0 && duty_q[i].cyc + 1 <= f * FRAME) duty = duty_q[i].duty;
    return (duty == 15) || ((p - BLANK) / SUB <= duty);
  endfunction

  task automatic set_duty(input int unsigned v);
    duty_t d;
    i_duty = 4'(v);
    d.cyc  = cyc;
    d.duty = v;
    duty_q.push_back(d);
  endtask
`endif

  // Pins seen during cycle c reflect scan position c-1; frame f shows the newest update
  // strobed at least two cycles before the frame starts.
  function automatic exp_t model(input int unsigned c);
    int unsigned s, f, d, p;
    upd_t        a;
    bit          have, lit;
    logic [31:0] vs;
    logic [55:0] rs;
    logic [7:0]  es, ds;
    exp_t        e;
    s = c - 1;
    f = s / FRAME;
    d = (s / SLOT) % N;
    p = s % SLOT;
    have = 1'b0;
    foreach (upd_q[i]) begin
      if (upd_q[i].cyc + 2 <= f * FRAME) begin
        a    = upd_q[i];
        have = 1'b1;
      end
    end
    e.frame = ((s % FRAME) == FRAME - 1);
    e.an    = 8'hFF;
    e.seg   = 7'h7F;
    e.dp    = 1'b1;
    lit     = have && (p >= BLANK);
    if (lit) begin
      es  = a.en >> d;
      lit = es[0];
    end
`ifdef SEVENSEG_DIMMING_EN
    if (lit) lit = dim_lit(f, p);
`endif
    if (lit) begin
      vs    = a.value >> (4 * d);
      rs    = a.raw >> (7 * d);
      ds    = a.dp >> d;
      e.an  = ~(8'b1 << d);
      e.seg = a.raw_mode ? rs[6:0] : HEX[vs[3:0]];
      e.dp  = ~ds[0];
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (!rst) exp_q.push_back(model(cyc + 1));
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && cyc > 0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty cyc=%0d: got no expected entry, required one", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({o_an, o_seg, o_dp, o_frame} !== {e.an, e.seg, e.dp, e.frame}) begin
          n_fail++;
          $display("FAIL scan cyc=%0d: got an=%h seg=%b dp=%b frame=%b, required an=%h seg=%b dp=%b frame=%b",
                   cyc, o_an, o_seg, o_dp, o_frame, e.an, e.seg, e.dp, e.frame);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, required %h", name, cyc, got, req);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_update(input logic [31:0] v, input logic [55:0] r, input logic rm,
                           input logic [7:0] dp, input logic [7:0] en);
    upd_t u;
    i_update   = 1'b1;
    i_value    = v;
    i_raw      = r;
    i_raw_mode = rm;
    i_dp       = dp;
    i_digit_en = en;
    u.cyc = cyc; u.value = v; u.raw = r; u.raw_mode = rm; u.dp = dp; u.en = en;
    upd_q.push_back(u);
    @(negedge clk);
    i_update = 1'b0;
  endtask

  function automatic logic [55:0] rnd56();
    return {24'($urandom), $urandom};
  endfunction

  initial begin
    #(600 * FRAME);
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v2, va, vb, vc, vr;
    logic [7:0]  dp2, dpa, dpb, dpc;
    logic [55:0] rr;
    int unsigned base, k, cnt;

    repeat (3) @(negedge clk);
    check("reset_an", 16'(o_an), 16'hFF);
    check("reset_seg_dp_frame", {7'b0, o_seg, o_dp, o_frame}, {7'b0, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;
`ifdef SEVENSEG_DIMMING_EN
    set_duty(15);
`endif

    // Hex scan
    wait_cyc(20);
    do_update(32'h89ABCDEF, rnd56(), 1'b0, 8'h01, 8'hFF);
    wait_cyc(FRAME + 1);
    check("hex_slot_blank", {o_an, o_seg, o_dp}, {8'hFF, 7'h7F, 1'b1});
    wait_cyc(FRAME + BLANK + 1);
    check("hex_digit0_F", {o_an, o_seg, o_dp}, {8'hFE, 7'b0111000, 1'b0});
    wait_cyc(FRAME + 7 * SLOT + BLANK + 1);
    check("hex_digit7_8", {o_an, o_seg, o_dp}, {8'h7F, 7'b0000000, 1'b1});

    // Tear-free mid-frame update
    wait_cyc(2 * FRAME + 3 * SLOT);
    v2  = $urandom;
    dp2 = 8'($urandom);
    do_update(v2, rnd56(), 1'b0, dp2, 8'hFF);
    wait_cyc(2 * FRAME + 5 * SLOT + BLANK + 1);
    check("tear_old_digit5", {o_an, o_seg, o_dp}, {8'hDF, 7'b0001000, 1'b1});
    wait_cyc(3 * FRAME);
    check("frame_pulse", 16'(o_frame), 16'h1);
    wait_cyc(3 * FRAME + 5 * SLOT + BLANK + 1);
    check("tear_new_digit5", {o_an, o_seg, o_dp}, {8'hDF, HEX[v2[23:20]], ~dp2[5]});

    // Update on the boundary cycle while another is pending
    wait_cyc(3 * FRAME + 6 * SLOT);
    va  = $urandom;
    dpa = 8'($urandom);
    do_update(va, rnd56(), 1'b0, dpa, 8'hFF);
    wait_cyc(4 * FRAME - 1);
    vb  = $urandom;
    dpb = 8'($urandom);
    do_update(vb, rnd56(), 1'b0, dpb, 8'hFF);
    wait_cyc(4 * FRAME + BLANK + 1);
    check("boundary_prev_staging", {o_an, o_seg, o_dp}, {8'hFE, HEX[va[3:0]], ~dpa[0]});

    // Update on the o_frame cycle
    k = 0;
    while (o_frame !== 1'b1 && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("frame_wait", 16'(o_frame), 16'h1);
    vc  = $urandom;
    dpc = 8'($urandom);
    do_update(vc, rnd56(), 1'b0, dpc, 8'hFF);
    wait_cyc(5 * FRAME + BLANK + 1);
    check("boundary_new_staging", {o_an, o_seg, o_dp}, {8'hFE, HEX[vb[3:0]], ~dpb[0]});
    wait_cyc(6 * FRAME + BLANK + 1);
    check("frame_cycle_update", {o_an, o_seg, o_dp}, {8'hFE, HEX[vc[3:0]], ~dpc[0]});

    // Raw mode with a single enabled digit
    wait_cyc(6 * FRAME + SLOT);
    rr = rnd56();
    rr[27:21] = 7'b1111110;
    dp2 = 8'($urandom);
    do_update($urandom, rr, 1'b1, dp2, 8'h08);
    wait_cyc(7 * FRAME + BLANK + 1);
    check("raw_disabled_digit0", {o_an, o_seg, o_dp}, {8'hFF, 7'h7F, 1'b1});
    wait_cyc(7 * FRAME + 3 * SLOT + BLANK + 1);
    check("raw_digit3", {o_an, o_seg, o_dp}, {8'hF7, 7'b1111110, ~dp2[3]});

    // Anode-on cycles within digit 3's slot: duty 3 then full
    wait_cyc(7 * FRAME + 4 * SLOT);
`ifdef SEVENSEG_DIMMING_EN
    set_duty(3);
`endif
    wait_cyc(8 * FRAME + 3 * SLOT + 1);
    cnt = 0;
    repeat (SLOT) begin
      if (o_an == 8'hF7) cnt++;
      @(negedge clk);
    end
`ifdef SEVENSEG_DIMMING_EN
    check("on_cycles_duty3", 16'(cnt), 16'd8);
    set_duty(15);
`else
    check("on_cycles_full", 16'(cnt), 16'(SLOT - BLANK));
`endif
    wait_cyc(9 * FRAME + 3 * SLOT + 1);
    cnt = 0;
    repeat (SLOT) begin
      if (o_an == 8'hF7) cnt++;
      @(negedge clk);
    end
    check("on_cycles_full_duty", 16'(cnt), 16'(SLOT - BLANK));

    // Randomised updates at arbitrary times
    wait_cyc(10 * FRAME);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, FRAME)) @(negedge clk);
      do_update($urandom, rnd56(), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    repeat (2 * FRAME) @(negedge clk);

    // Asynchronous reset while a digit is lit
    vr = $urandom;
    do_update(vr, rnd56(), 1'b0, 8'h00, 8'hFF);
    base = (cyc / FRAME + 2) * FRAME;
    wait_cyc(base + 2 * SLOT + BLANK + 3);
    check("pre_reset_lit_an", 16'(o_an), 16'h00FB);
    #2 rst = 1'b1;
    #1;
    check("async_reset_an", 16'(o_an), 16'hFF);
    check("async_reset_seg_dp", {7'b0, o_seg, o_dp, o_frame}, {7'b0, 7'h7F, 1'b1, 1'b0});
    exp_q.delete();
    upd_q.delete();
`ifdef SEVENSEG_DIMMING_EN
    duty_q.delete();
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
`ifdef SEVENSEG_DIMMING_EN
    set_duty(15);
`endif
    wait_cyc(BLANK + 1);
    check("post_reset_blank", {o_an, o_seg, o_dp}, {8'hFF, 7'h7F, 1'b1});
    wait_cyc(10);
    vr = $urandom;
    do_update(vr, rnd56(), 1'b0, 8'h00, 8'h01);
    wait_cyc(FRAME + BLANK + 1);
    check("post_reset_digit0", {o_an, o_seg, o_dp}, {8'hFE, HEX[vr[3:0]], 1'b1});
    wait_cyc(2 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
